// File: rtl/lsq_issue_sched.sv
// rtl/lsq_issue_sched.sv - oldest-first LSQ issue scheduler with one-deep request hold
module lsq_issue_sched #(
    parameter int LsqSize = 16,
    parameter int LsqIdxW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LsqSize-1:0]   lsq_entry_vld,
    input  logic [LsqSize-1:0]   entry_can_execute,
    input  logic [2*LsqSize-1:0] lsq_entry_channel_id,
    input  logic [LsqIdxW-1:0]   lsq_btm_ptr,
    input  logic [LsqSize-1:0]   lsq_entry_dealloc,
    input  logic                 flush,
    output logic                 iss_valid,
    output logic [LsqIdxW-1:0]   iss_idx,
    output logic [2:0]           iss_channel_1hot,
    input  logic [2:0]           iss_ready,
    output logic [LsqSize-1:0]   issued_vec,
    output logic [3*16-1:0]      iss_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    logic [1:0]          chan_id [LsqSize];
    logic [LsqSize-1:0]  cand;
    logic                sel_found;
    logic [LsqIdxW-1:0]  sel_idx;
    logic [LsqIdxW-1:0]  scan_idx;
    logic [2:0]          sel_1hot;
    logic                fire;
    logic                held_dealloc;
    logic [LsqSize-1:0]  fire_vec;

    assign iss_valid = (state == HOLD);

    // Candidate vector: credited, allocated, not yet sent, legal channel, and not the entry already on the bus
    always_comb begin
        for (int i = 0; i < LsqSize; i++) begin
            chan_id[i] = lsq_entry_channel_id[2*i +: 2];
            cand[i]    = lsq_entry_vld[i] & entry_can_execute[i] & ~issued_vec[i] &
                         (chan_id[i] != 2'd3) &
                         ~(iss_valid && (iss_idx == LsqIdxW'(i)));
        end
    end

    // Oldest-first pick: scan upward from the bottom pointer, wrapping through the top entry
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < LsqSize; k++) begin
            scan_idx = lsq_btm_ptr + LsqIdxW'(k);
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Channel decode of the selected entry; an illegal id can never be selected
    always_comb begin
        case (chan_id[sel_idx])
            2'd0:    sel_1hot = 3'b001;
            2'd1:    sel_1hot = 3'b010;
            2'd2:    sel_1hot = 3'b100;
            default: sel_1hot = 3'b000;
        endcase
    end

    // Handshake terms: only the ready of the held entry's channel matters
    always_comb begin
        fire         = iss_valid & |(iss_channel_1hot & iss_ready);
        held_dealloc = iss_valid & lsq_entry_dealloc[iss_idx];
        fire_vec     = fire ? (LsqSize'(1) << iss_idx) : '0;
    end

    // Request FSM, issued tracking and per-channel counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            iss_idx          <= '0;
            iss_channel_1hot <= 3'b000;
            issued_vec       <= '0;
            iss_cnt          <= '0;
        end else begin
            // Dealloc is applied after the fire bit so a same-cycle dealloc leaves the entry clear
            if (flush) begin
                issued_vec <= '0;
            end else begin
                issued_vec <= (issued_vec | fire_vec) & ~lsq_entry_dealloc;
            end

            for (int c = 0; c < 3; c++) begin
                if (fire && !flush && iss_channel_1hot[c]) begin
                    iss_cnt[16*c +: 16] <= iss_cnt[16*c +: 16] + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (!flush && sel_found) begin
                        state            <= HOLD;
                        iss_idx          <= sel_idx;
                        iss_channel_1hot <= sel_1hot;
                    end
                end
                HOLD: begin
                    if (flush || (held_dealloc && !fire)) begin
                        state            <= IDLE;
                        iss_channel_1hot <= 3'b000;
                    end else if (fire) begin
                        if (sel_found) begin
                            iss_idx          <= sel_idx;
                            iss_channel_1hot <= sel_1hot;
                        end else begin
                            state            <= IDLE;
                            iss_channel_1hot <= 3'b000;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    iss_channel_1hot <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_issue_sched.sv
// tb/tb_lsq_issue_sched.sv - directed-vector bench for lsq_issue_sched
module tb_lsq_issue_sched;

    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   lsq_entry_vld;
    logic [N-1:0]   entry_can_execute;
    logic [2*N-1:0] lsq_entry_channel_id;
    logic [W-1:0]   lsq_btm_ptr;
    logic [N-1:0]   lsq_entry_dealloc;
    logic           flush;
    logic           iss_valid;
    logic [W-1:0]   iss_idx;
    logic [2:0]     iss_channel_1hot;
    logic [2:0]     iss_ready;
    logic [N-1:0]   issued_vec;
    logic [47:0]    iss_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] exp_cnt [3];

    lsq_issue_sched #(.LsqSize(N), .LsqIdxW(W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lsq_entry_vld        (lsq_entry_vld),
        .entry_can_execute    (entry_can_execute),
        .lsq_entry_channel_id (lsq_entry_channel_id),
        .lsq_btm_ptr          (lsq_btm_ptr),
        .lsq_entry_dealloc    (lsq_entry_dealloc),
        .flush                (flush),
        .iss_valid            (iss_valid),
        .iss_idx              (iss_idx),
        .iss_channel_1hot     (iss_channel_1hot),
        .iss_ready            (iss_ready),
        .issued_vec           (issued_vec),
        .iss_cnt              (iss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [1:0] c);
        lsq_entry_channel_id[2*i +: 2] = c;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt0"}, 64'(iss_cnt[15:0]),  64'(exp_cnt[0]));
        chk({tag, "_cnt1"}, 64'(iss_cnt[31:16]), 64'(exp_cnt[1]));
        chk({tag, "_cnt2"}, 64'(iss_cnt[47:32]), 64'(exp_cnt[2]));
    endtask

    task automatic clean();
        lsq_entry_vld     = '0;
        entry_can_execute = '0;
        iss_ready         = 3'b000;
        flush             = 1'b0;
        lsq_entry_dealloc = '1;
        step();
        lsq_entry_dealloc = '0;
        step();
    endtask

    initial begin
        int n;
        int cyc;

        rst_n                = 1'b0;
        lsq_entry_vld        = '0;
        entry_can_execute    = '0;
        lsq_entry_channel_id = '0;
        lsq_btm_ptr          = '0;
        lsq_entry_dealloc    = '0;
        flush                = 1'b0;
        iss_ready            = 3'b000;
        for (int c = 0; c < 3; c++) exp_cnt[c] = 16'd0;

        // reset state
        #1;
        step();
        step();
        chk("rst_valid",  64'(iss_valid), 64'd0);
        chk("rst_idx",    64'(iss_idx), 64'd0);
        chk("rst_1hot",   64'(iss_channel_1hot), 64'd0);
        chk("rst_issued", 64'(issued_vec), 64'd0);
        chk("rst_cnt",    64'(iss_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // oldest-first with wrap: btm=14, candidates 2 (ch1) and 15 (ch0)
        lsq_btm_ptr       = 4'd14;
        lsq_entry_vld     = 16'h8004;
        entry_can_execute = 16'h8004;
        set_ch(15, 2'd0);
        set_ch(2, 2'd1);
        iss_ready         = 3'b111;
        step();
        chk("wrap_v1",    64'(iss_valid), 64'd1);
        chk("wrap_idx1",  64'(iss_idx), 64'd15);
        chk("wrap_1hot1", 64'(iss_channel_1hot), 64'b001);
        step();
        exp_cnt[0]++;
        chk("wrap_idx2",  64'(iss_idx), 64'd2);
        chk("wrap_1hot2", 64'(iss_channel_1hot), 64'b010);
        step();
        exp_cnt[1]++;
        chk("wrap_v3",     64'(iss_valid), 64'd0);
        chk("wrap_1hot3",  64'(iss_channel_1hot), 64'd0);
        chk("wrap_issued", 64'(issued_vec), 64'h8004);
        chk_cnt("wrap");
        clean();
        chk("clean_issued", 64'(issued_vec), 64'd0);

        // backpressure: entry 5 on channel 1, ready only on other channels
        lsq_btm_ptr       = 4'd0;
        lsq_entry_vld     = 16'h0020;
        entry_can_execute = 16'h0020;
        set_ch(5, 2'd1);
        iss_ready         = 3'b101;
        step();
        chk("bp_load_idx", 64'(iss_idx), 64'd5);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                set_ch(5, 2'd0);
                entry_can_execute = 16'h0000;
            end
            if (k == 3) begin
                set_ch(5, 2'd1);
                entry_can_execute = 16'h0020;
            end
            step();
            chk("bp_hold_v",    64'(iss_valid), 64'd1);
            chk("bp_hold_idx",  64'(iss_idx), 64'd5);
            chk("bp_hold_1hot", 64'(iss_channel_1hot), 64'b010);
        end
        chk_cnt("bp_nofire");
        iss_ready = 3'b010;
        step();
        exp_cnt[1]++;
        chk("bp_fire_v",      64'(iss_valid), 64'd0);
        chk("bp_fire_issued", 64'(issued_vec), 64'h0020);
        chk_cnt("bp_fire");
        clean();

        // cancel: dealloc of held entry 3 without fire; entry 4 must not load that cycle
        lsq_entry_vld     = 16'h0008;
        entry_can_execute = 16'h0008;
        set_ch(3, 2'd0);
        set_ch(4, 2'd0);
        step();
        chk("cx_load_idx", 64'(iss_idx), 64'd3);
        lsq_entry_dealloc = 16'h0008;
        lsq_entry_vld     = 16'h0010;
        entry_can_execute = 16'h0010;
        step();
        lsq_entry_dealloc = '0;
        chk("cx_valid",  64'(iss_valid), 64'd0);
        chk("cx_1hot",   64'(iss_channel_1hot), 64'd0);
        chk("cx_issued", 64'(issued_vec), 64'd0);
        chk_cnt("cx");
        step();
        chk("cx_next_v",   64'(iss_valid), 64'd1);
        chk("cx_next_idx", 64'(iss_idx), 64'd4);
        clean();

        // flush beats fire: issue 6, hold 7, then flush together with ready
        lsq_btm_ptr       = 4'd6;
        lsq_entry_vld     = 16'h01C0;
        entry_can_execute = 16'h01C0;
        set_ch(6, 2'd2);
        set_ch(7, 2'd2);
        set_ch(8, 2'd0);
        iss_ready         = 3'b100;
        step();
        chk("fl_idx6", 64'(iss_idx), 64'd6);
        step();
        exp_cnt[2]++;
        chk("fl_idx7",    64'(iss_idx), 64'd7);
        chk("fl_issued6", 64'(issued_vec), 64'h0040);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid",  64'(iss_valid), 64'd0);
        chk("fl_1hot",   64'(iss_channel_1hot), 64'd0);
        chk("fl_issued", 64'(issued_vec), 64'd0);
        chk_cnt("fl");
        clean();

        // illegal channel: entry 0 on id 3 never issues, entry 1 still does
        lsq_btm_ptr       = 4'd0;
        lsq_entry_vld     = 16'h0003;
        entry_can_execute = 16'h0003;
        set_ch(0, 2'd3);
        set_ch(1, 2'd0);
        iss_ready         = 3'b001;
        step();
        chk("ill_idx",  64'(iss_idx), 64'd1);
        chk("ill_1hot", 64'(iss_channel_1hot), 64'b001);
        step();
        exp_cnt[0]++;
        for (int k = 0; k < 3; k++) begin
            chk("ill_idle", 64'(iss_valid), 64'd0);
            step();
        end
        chk("ill_issued", 64'(issued_vec), 64'h0002);
        chk_cnt("ill");
        clean();

        // reset while holding with matching ready: request abandoned
        lsq_entry_vld     = 16'h0200;
        entry_can_execute = 16'h0200;
        set_ch(9, 2'd1);
        step();
        chk("rh_hold", 64'(iss_valid), 64'd1);
        iss_ready = 3'b010;
        rst_n     = 1'b0;
        step();
        for (int c = 0; c < 3; c++) exp_cnt[c] = 16'd0;
        chk("rh_valid",  64'(iss_valid), 64'd0);
        chk("rh_issued", 64'(issued_vec), 64'd0);
        chk_cnt("rh");
        rst_n = 1'b1;
        clean();

        // channel-2 counter wrap via back-to-back issue across all entries
        lsq_entry_vld        = '1;
        entry_can_execute    = '1;
        lsq_entry_channel_id = {N{2'b10}};
        lsq_entry_dealloc    = '1;
        iss_ready            = 3'b100;
        n   = 0;
        cyc = 0;
        while (n < 65535 && cyc < 70000) begin
            if (iss_valid && iss_channel_1hot[2]) n++;
            step();
            cyc++;
        end
        iss_ready = 3'b000;
        chk("cw_budget", 64'(cyc < 70000), 64'd1);
        chk("cw_ffff",   64'(iss_cnt[47:32]), 64'hFFFF);
        chk("cw_hold",   64'(iss_valid), 64'd1);
        iss_ready = 3'b100;
        step();
        exp_cnt[2] = 16'd0;
        chk_cnt("cw");
        clean();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
